controller_pro_mc: RTL and testbench
====================================

Name: controller_pro_mc

Overview:
- Next-generation landscape-sampling sequencer; drives the ISI-record / processing windows in clk_main.
- Generalised to N_CH timestamp channels.
- Window lengths are runtime-programmable, and the window counters are now internal.
- Adds a start/done handshake, single-shot vs continuous mode, and abort.
- Sits between the clk_low tick source and the per-channel Cnt_4 / RAM_zout datapath.

Parameters:
N_CH, 4, number of timestamp channels
BIT_W1, 15, width of the ISI-window counter and w1_len
BIT_W4, 20, width of the processing-window counter and w4_len
BIT_FRM, 16, width of the completed-frame counter

Ports:
clk_main  in  1  system clock
rst  in  1  asynchronous, active-low reset
clk_low  in  1  slow sampling clock; asynchronous to clk_main
start  in  1  level; begins a run when sampled high in S_IDLE
mode_cont  in  1  1 = loop frames until abort; 0 = single frame; sampled at start
abort  in  1  synchronous abort request
w1_len  in  BIT_W1  ISI window length in clk_low ticks; 0 is treated as 1
w4_len  in  BIT_W4  processing window length in clk_main cycles; 0 is treated as 1
tstamp_z  in  N_CH  per-channel timestamp-zero flag
ce_cnt_4  out  N_CH  per-channel Cnt_4 enable
clr_cnt_4  out  N_CH  per-channel Cnt_4 clear
clr_ram_zout  out  1  RAM_zout clear
we_zout  out  1  RAM_zout write enable
ce_ram  out  1  RAM clock enable
busy  out  1  high in every state except S_IDLE
done  out  1  one-cycle pulse at the end of a frame
phase  out  3  current state encoding
w1_cnt  out  BIT_W1  ISI tick counter
w4_cnt  out  BIT_W4  processing cycle counter
frame_cnt  out  BIT_FRM  completed frames; wraps modulo 2^BIT_FRM

Behaviour:
- Reset (rst low, asynchronous):
  - state = S_IDLE; all counters 0.
  - Output values: ce_* = 0; clr_cnt_4 = all 1; clr_ram_zout = 1; we_zout = 0; ce_ram = 0; busy = 0; done = 0.
- clk_low handling: 2-flop synchroniser, then a rising-edge detector giving tick (one clk_main cycle). Tick latency from the clk_low edge is 3 clk_main edges.
- len_w1 = max(w1_len, 1) and len_w4 = max(w4_len, 1), both latched on entry to S_INIT. Mid-run changes to the inputs are ignored.
- States: S_IDLE=0, S_INIT=1, S_ISI=2, S_PROC=3, S_WRAP=4.
- S_IDLE:
  - clr_* asserted; done is low except for the pulse described under S_WRAP.
  - start=1 (and abort=0) -> S_INIT, latching mode_cont.
- S_INIT (1 cycle):
  - Clear w1_cnt, w4_cnt, all Cnt_4; clr_ram_zout = 1.
  - -> S_ISI.
- S_ISI:
  - ce_ram = 1.
  - On tick: ce_cnt_4 = all 1; clr_cnt_4[i] = tstamp_z[i]; w1_cnt += 1.
  - Off tick: ce_cnt_4 = 0; clr_cnt_4 = 0.
  - When w1_cnt == len_w1 -> S_PROC. Exit is one cycle after the final tick, so exactly len_w1 ticks are counted.
- S_PROC:
  - ce_ram = 1; we_zout = 1; w4_cnt += 1 each cycle; ce_cnt_4 = 0; clr_cnt_4 = all 1.
  - When w4_cnt == len_w4 - 1 -> S_WRAP. Total len_w4 cycles.
- S_WRAP:
  - Wait for a tick, so the next frame is aligned to clk_low.
  - On tick: frame_cnt += 1; done = 1 for one cycle.
  - Continuous mode: -> S_INIT. Single-shot mode: -> S_IDLE.
- abort:
  - From any state other than S_IDLE, abort -> S_IDLE next cycle, with no done pulse and frame_cnt unchanged.
  - abort has priority over every other transition.
  - abort together with start in S_IDLE -> remain in S_IDLE.
- Simultaneous tick and state exit: the tick belongs to the current state; no double count.
- Counter saturation: w1_cnt and w4_cnt never exceed len_*. An illegal phase encoding -> S_IDLE next cycle.
- All control outputs are registered, so each is valid one cycle after the state it decodes.

Decomposition:
- Package ctrl_pro_pkg holds:
  - state encodings S_IDLE to S_WRAP;
  - the default widths;
  - function clamp1(len), returning max(len, 1).
- One sub-module, clk_low_tick: the 2-flop synchroniser plus edge detector; output tick; rst active-low.

Test Plan:
- Reset released, then start=1, mode_cont=0, w1_len=3, w4_len=5, clk_low period 8 clk_main:
  - exactly 3 ticks in S_ISI;
  - we_zout high for exactly 5 cycles;
  - one done pulse; frame_cnt = 1; busy drops.
- tstamp_z=4'b0101 on each tick in S_ISI -> clr_cnt_4 = 4'b0101 together with ce_cnt_4 = 4'b1111 on those cycles only.
- Continuous mode, w1_len=2, w4_len=4:
  - 3 done pulses, each spaced by the S_WRAP re-alignment to a tick;
  - frame_cnt = 3;
  - abort asserted during the 4th S_PROC -> S_IDLE next cycle, no 4th done.
- w1_len=0, w4_len=0 -> treated as 1: single tick in S_ISI, single we_zout cycle, done asserted.
- rst pulsed low mid-S_PROC -> outputs take their reset values asynchronously; frame_cnt = 0; the next start runs a full frame.
- frame_cnt at 2^16-1 plus one completed frame -> wraps to 0.

Source files
------------

// File: rtl/ctrl_pro_pkg.sv
// Shared state encodings, default widths and length clamp for the sampling sequencer.
package ctrl_pro_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int BIT_W1_DEF  = 15;
  localparam int BIT_W4_DEF  = 20;
  localparam int BIT_FRM_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ISI  = 3'd2,
    S_PROC = 3'd3,
    S_WRAP = 3'd4
  } state_t;

  function automatic logic [31:0] clamp1(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/clk_low_tick.sv
// Brings clk_low into clk_main: 2-flop synchroniser plus registered rising-edge detect.
// tick is a one-cycle pulse, 3 clk_main edges after the clk_low rising edge.
module clk_low_tick (
  input  logic clk_main,
  input  logic rst,
  input  logic clk_low,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync1   <= clk_low;
      sync2   <= sync1;
      sync2_d <= sync2;
      tick    <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/controller_pro_mc.sv
// Landscape-sampling sequencer: ISI-record window in clk_low ticks, processing window in
// clk_main cycles, frame realigned to clk_low; control outputs registered (one cycle lag).
module controller_pro_mc
  import ctrl_pro_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int BIT_W1  = BIT_W1_DEF,
  parameter int BIT_W4  = BIT_W4_DEF,
  parameter int BIT_FRM = BIT_FRM_DEF
) (
  input  logic               clk_main,
  input  logic               rst,
  input  logic               clk_low,
  input  logic               start,
  input  logic               mode_cont,
  input  logic               abort,
  input  logic [BIT_W1-1:0]  w1_len,
  input  logic [BIT_W4-1:0]  w4_len,
  input  logic [N_CH-1:0]    tstamp_z,
  output logic [N_CH-1:0]    ce_cnt_4,
  output logic [N_CH-1:0]    clr_cnt_4,
  output logic               clr_ram_zout,
  output logic               we_zout,
  output logic               ce_ram,
  output logic               busy,
  output logic               done,
  output logic [2:0]         phase,
  output logic [BIT_W1-1:0]  w1_cnt,
  output logic [BIT_W4-1:0]  w4_cnt,
  output logic [BIT_FRM-1:0] frame_cnt
);

  state_t             state;
  state_t             state_nx;
  logic               tick;
  logic               run;
  logic               mode_q;
  logic [BIT_W1-1:0]  len_w1;
  logic [BIT_W4-1:0]  len_w4;

  logic [N_CH-1:0]    ce_cnt_4_d;
  logic [N_CH-1:0]    clr_cnt_4_d;
  logic               clr_ram_zout_d;
  logic               we_zout_d;
  logic               ce_ram_d;
  logic               busy_d;
  logic               done_d;

  clk_low_tick u_clk_low_tick (
    .clk_main (clk_main),
    .rst      (rst),
    .clk_low  (clk_low),
    .tick     (tick)
  );

  // An abort outside idle freezes all counting and forces idle decode.
  assign run   = !(abort && (state != S_IDLE));
  assign phase = state;

  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!run) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && !abort) state_nx = S_INIT;
        S_INIT:  state_nx = S_ISI;
        S_ISI:   if (w1_cnt == len_w1) state_nx = S_PROC;
        S_PROC:  if (w4_cnt == len_w4 - BIT_W4'(1)) state_nx = S_WRAP;
        S_WRAP:  if (tick) state_nx = mode_q ? S_INIT : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Lengths and mode are captured once per run so mid-run input changes are ignored.
  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      len_w1    <= '0;
      len_w4    <= '0;
      mode_q    <= 1'b0;
      w1_cnt    <= '0;
      w4_cnt    <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == S_IDLE && state_nx == S_INIT) begin
        len_w1 <= BIT_W1'(clamp1(32'(w1_len)));
        len_w4 <= BIT_W4'(clamp1(32'(w4_len)));
        mode_q <= mode_cont;
      end
      if (run) begin
        case (state)
          S_INIT: begin
            w1_cnt <= '0;
            w4_cnt <= '0;
          end
          S_ISI:   if (tick && (w1_cnt < len_w1)) w1_cnt <= w1_cnt + BIT_W1'(1);
          S_PROC:  if (w4_cnt < len_w4) w4_cnt <= w4_cnt + BIT_W4'(1);
          S_WRAP:  if (tick) frame_cnt <= frame_cnt + BIT_FRM'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ce_cnt_4_d     = '0;
    clr_cnt_4_d    = '1;
    clr_ram_zout_d = 1'b1;
    we_zout_d      = 1'b0;
    ce_ram_d       = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    if (run) begin
      case (state)
        S_INIT: busy_d = 1'b1;
        S_ISI: begin
          busy_d         = 1'b1;
          ce_ram_d       = 1'b1;
          clr_ram_zout_d = 1'b0;
          clr_cnt_4_d    = '0;
          // A tick arriving after the window is full belongs to no Cnt_4 sample.
          if (tick && (w1_cnt != len_w1)) begin
            ce_cnt_4_d  = '1;
            clr_cnt_4_d = tstamp_z;
          end
        end
        S_PROC: begin
          busy_d         = 1'b1;
          ce_ram_d       = 1'b1;
          we_zout_d      = 1'b1;
          clr_ram_zout_d = 1'b0;
        end
        S_WRAP: begin
          busy_d         = 1'b1;
          clr_ram_zout_d = 1'b0;
          done_d         = tick;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main or negedge rst) begin
    if (!rst) begin
      ce_cnt_4     <= '0;
      clr_cnt_4    <= '1;
      clr_ram_zout <= 1'b1;
      we_zout      <= 1'b0;
      ce_ram       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ce_cnt_4     <= ce_cnt_4_d;
      clr_cnt_4    <= clr_cnt_4_d;
      clr_ram_zout <= clr_ram_zout_d;
      we_zout      <= we_zout_d;
      ce_ram       <= ce_ram_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_controller_pro_mc.sv
// Scoreboard bench for controller_pro_mc; frame counter narrowed to 4 bits so wrap is reachable.
`timescale 1ns/1ps
module tb_controller_pro_mc;
  import ctrl_pro_pkg::*;

  localparam int N_CH    = 4;
  localparam int BIT_W1  = 15;
  localparam int BIT_W4  = 20;
  localparam int BIT_FRM = 4;

  logic               clk_main = 1'b0;
  logic               rst = 1'b0;
  logic               clk_low = 1'b0;
  logic               start = 1'b0;
  logic               mode_cont = 1'b0;
  logic               abort = 1'b0;
  logic [BIT_W1-1:0]  w1_len = '0;
  logic [BIT_W4-1:0]  w4_len = '0;
  logic [N_CH-1:0]    tstamp_z = '0;
  logic [N_CH-1:0]    ce_cnt_4;
  logic [N_CH-1:0]    clr_cnt_4;
  logic               clr_ram_zout;
  logic               we_zout;
  logic               ce_ram;
  logic               busy;
  logic               done;
  logic [2:0]         phase;
  logic [BIT_W1-1:0]  w1_cnt;
  logic [BIT_W4-1:0]  w4_cnt;
  logic [BIT_FRM-1:0] frame_cnt;

  controller_pro_mc #(
    .N_CH(N_CH), .BIT_W1(BIT_W1), .BIT_W4(BIT_W4), .BIT_FRM(BIT_FRM)
  ) dut (
    .clk_main(clk_main), .rst(rst), .clk_low(clk_low), .start(start),
    .mode_cont(mode_cont), .abort(abort), .w1_len(w1_len), .w4_len(w4_len),
    .tstamp_z(tstamp_z), .ce_cnt_4(ce_cnt_4), .clr_cnt_4(clr_cnt_4),
    .clr_ram_zout(clr_ram_zout), .we_zout(we_zout), .ce_ram(ce_ram),
    .busy(busy), .done(done), .phase(phase), .w1_cnt(w1_cnt),
    .w4_cnt(w4_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk_main = ~clk_main;
  initial begin
    #3;
    forever #40 clk_low = ~clk_low;
  end

  typedef struct {
    int frm;
    int n_ce;
    int n_we;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  int cyc = 0;
  int last_done = 0;
  int acc_ce = 0;
  int acc_we = 0;
  int acc_bad = 0;
  logic [2:0] prev_phase = 3'd0;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Monitor: accumulates per-frame activity, pops the scoreboard on each done pulse.
  always @(negedge clk_main) begin
    cyc++;
    if (rst) begin
      if (we_zout) acc_we++;
      if (ce_cnt_4 != '0) begin
        acc_ce++;
        if (ce_cnt_4 != 4'hF || clr_cnt_4 != tstamp_z) acc_bad++;
      end else if (phase == S_ISI && prev_phase == S_ISI && clr_cnt_4 != '0) begin
        acc_bad++;
      end
      if (done) begin
        n_done++;
        check("done_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("frame_cnt", frame_cnt, e.frm);
          check("isi_ticks", acc_ce, e.n_ce);
          check("we_cycles", acc_we, e.n_we);
          check("clr_pattern_errs", acc_bad, 0);
          if (e.gap != 0) check("done_gap", cyc - last_done, e.gap);
        end
        last_done = cyc;
      end
      if (phase == S_INIT) begin
        acc_ce  = 0;
        acc_we  = 0;
        acc_bad = 0;
      end
    end else begin
      acc_ce  = 0;
      acc_we  = 0;
      acc_bad = 0;
    end
    prev_phase = phase;
  end

  task automatic step();
    @(negedge clk_main);
    #1;
  endtask

  task automatic run(input int l1, input int l4, input logic cont, input logic [3:0] tz);
    w1_len    = BIT_W1'(l1);
    w4_len    = BIT_W4'(l4);
    mode_cont = cont;
    tstamp_z  = tz;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_done < target; i++) step();
    check(name, n_done, target);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
    for (int i = 0; i < budget && phase != p; i++) step();
    check(name, phase, p);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ce_cnt_4"}, ce_cnt_4, 0);
    check({tag, "_clr_cnt_4"}, clr_cnt_4, 15);
    check({tag, "_clr_ram_zout"}, clr_ram_zout, 1);
    check({tag, "_we_zout"}, we_zout, 0);
    check({tag, "_ce_ram"}, ce_ram, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    repeat (3) step();
    check_idle_outputs("reset");
    check("reset_w1_cnt", w1_cnt, 0);
    check("reset_w4_cnt", w4_cnt, 0);
    rst = 1'b1;
    repeat (4) step();

    // Single-shot 3/5 with timestamp pattern 0101.
    exp_q.push_back('{1, 3, 5, 0});
    run(3, 5, 1'b0, 4'b0101);
    wait_done(1, 200, "t1_done_seen");
    step();
    check("t1_busy_after", busy, 0);
    check("t1_phase_after", phase, 0);

    // Zero lengths behave as one.
    exp_q.push_back('{2, 1, 1, 0});
    run(0, 0, 1'b0, 4'b1010);
    wait_done(2, 200, "t2_done_seen");
    step();
    check("t2_busy_after", busy, 0);

    // Asynchronous reset in the middle of the processing window.
    run(3, 5, 1'b0, 4'b0011);
    wait_phase(S_PROC, 200, "t3_reach_proc");
    #2 rst = 1'b0;
    #1 check_idle_outputs("midrst");
    step();
    rst = 1'b1;
    repeat (2) step();
    exp_q.push_back('{1, 3, 5, 0});
    run(3, 5, 1'b0, 4'b0011);
    wait_done(3, 200, "t3_done_seen");

    // Continuous 2/4: three frames then abort inside the fourth processing window.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    exp_q.push_back('{1, 2, 4, 0});
    exp_q.push_back('{2, 2, 4, 24});
    exp_q.push_back('{3, 2, 4, 24});
    run(2, 4, 1'b1, 4'b0110);
    wait_done(6, 400, "t4_three_dones");
    wait_phase(S_PROC, 100, "t4_reach_proc4");
    abort = 1'b1;
    step();
    abort = 1'b0;
    mode_cont = 1'b0;
    check("abort_phase", phase, 0);
    check("abort_busy", busy, 0);
    check("abort_we_zout", we_zout, 0);
    check("abort_frame_cnt", frame_cnt, 3);
    repeat (40) step();
    check("abort_no_done", n_done, 6);
    check("abort_frame_hold", frame_cnt, 3);

    // Continuous 1/1 until frame_cnt wraps through zero.
    for (int k = 1; k <= 13; k++)
      exp_q.push_back('{(3 + k) % 16, 1, 1, (k == 1) ? 0 : 16});
    run(1, 1, 1'b1, 4'b1001);
    wait_done(19, 400, "t5_wrap_dones");
    abort = 1'b1;
    step();
    abort = 1'b0;
    mode_cont = 1'b0;
    check("wrap_frame_cnt", frame_cnt, 0);
    check("wrap_phase", phase, 0);
    repeat (20) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
